// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline writebacks with
// buffered out-of-order MDU results and tracks MDU-pending destinations.
// Latency: pipe path 1 cycle; MDU result accepted at edge N is written at N+1 at the earliest.
// Backpressure: mdu_ready_o drops when the result FIFO is full; a starved FIFO
// raises stall_o to request one pipeline writeback bubble.
//
// Ports:
//   clk_i, rst_i                         clock (rising edge), async active-high reset
//   pipe_regwrite_i/pipe_rd_i/pipe_data_i pipeline writeback request (rd 0 = none)
//   mdu_valid_i/mdu_ready_o/mdu_rd_i/mdu_data_i  MDU result handshake
//   issue_valid_i/issue_rd_i             MDU issue, marks destination busy
//   RegWrite_o/RDaddr_o/RDdata_o         registered register-file write port
//   busy_o                               per-register MDU-pending scoreboard
//   stall_o                              registered bubble request
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_regwrite_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_data_i,
  input  logic        mdu_valid_i,
  output logic        mdu_ready_o,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_data_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o,
  output logic [31:0] busy_o,
  output logic        stall_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Result FIFO storage and pointers; depth is a power of two so the
  // pointers wrap naturally.
  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [4:0]    fifo_rd_d   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          reg_write_q, reg_write_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [31:0]   busy_q, busy_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  logic pipe_eff;
  logic fifo_nonempty;
  logic pop;
  logic push;

  // Ready comes only from the registered count, so a pop in the same cycle
  // never reopens a full FIFO.
  assign mdu_ready_o   = (count_q < CW'(FIFO_DEPTH));
  assign pipe_eff      = pipe_regwrite_i && (pipe_rd_i != 5'd0);
  assign fifo_nonempty = (count_q != '0);
  assign pop           = !pipe_eff && fifo_nonempty;
  // Results for x0 are consumed by the handshake but never stored.
  assign push          = mdu_valid_i && mdu_ready_o && (mdu_rd_i != 5'd0);

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    reg_write_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    busy_d      = busy_q;
    starve_d    = starve_q;
    stall_d     = stall_q;

    if (push) begin
      fifo_rd_d[wr_ptr_q]   = mdu_rd_i;
      fifo_data_d[wr_ptr_q] = mdu_data_i;
      wr_ptr_d              = AW'(wr_ptr_q + 1'b1);
    end

    if (pipe_eff) begin
      reg_write_d = 1'b1;
      rd_addr_d   = pipe_rd_i;
      rd_data_d   = pipe_data_i;
    end else if (fifo_nonempty) begin
      reg_write_d = 1'b1;
      rd_addr_d   = fifo_rd_q[rd_ptr_q];
      rd_data_d   = fifo_data_q[rd_ptr_q];
      rd_ptr_d    = AW'(rd_ptr_q + 1'b1);
      busy_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
    end

    if (push && !pop) begin
      count_d = CW'(count_q + 1'b1);
    end else if (pop && !push) begin
      count_d = CW'(count_q - 1'b1);
    end

    // Applied after the pop clear so a same-cycle reissue keeps the bit set.
    if (issue_valid_i && (issue_rd_i != 5'd0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;

    if (pop || !fifo_nonempty) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = SW'(starve_q + 1'b1);
    end

    // The counter saturates until the next pop, so stall tracks it directly.
    stall_d = (starve_d == SW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      busy_q      <= '0;
      starve_q    <= '0;
      stall_q     <= 1'b0;
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
    end
  end

  assign RegWrite_o = reg_write_q;
  assign RDaddr_o   = rd_addr_q;
  assign RDdata_o   = rd_data_q;
  assign busy_o     = busy_q;
  assign stall_o    = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_regwrite;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] busy;
  logic        stall;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pipe_regwrite_i (pipe_regwrite),
    .pipe_rd_i       (pipe_rd),
    .pipe_data_i     (pipe_data),
    .mdu_valid_i     (mdu_valid),
    .mdu_ready_o     (mdu_ready),
    .mdu_rd_i        (mdu_rd),
    .mdu_data_i      (mdu_data),
    .issue_valid_i   (issue_valid),
    .issue_rd_i      (issue_rd),
    .RegWrite_o      (reg_write),
    .RDaddr_o        (rd_addr),
    .RDdata_o        (rd_data),
    .busy_o          (busy),
    .stall_o         (stall)
  );

  always #5 clk = ~clk;

  task automatic idle();
    pipe_regwrite = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
    pipe_regwrite = 1'b1; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step(); step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b want 0", reg_write); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rd_addr); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", rd_data); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", mdu_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_pipe();
    idle();
    pipe(5'd5, 32'hDEADBEEF);
    step();
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL pipe_regwrite got %b want 1", reg_write); end
    checks++; if (rd_addr !== 5'd5) begin errors++; $display("FAIL pipe_addr got %0d want 5", rd_addr); end
    checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_data got %h want deadbeef", rd_data); end
    pipe(5'd0, 32'h11111111);
    step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL pipe_rd0_regwrite got %b want 0", reg_write); end
    checks++; if (rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_hold got %0d/%h want 5/deadbeef", rd_addr, rd_data); end
    idle();
  endtask

  task automatic test_mdu_delayed();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL issue_busy got %h want 00000080", busy); end
    idle();
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h12;
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      pipe(5'd1, 32'h100 + k);
      step();
      checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd1 || rd_data !== 32'h100 + k) begin errors++; $display("FAIL blocked_pipe%0d got %b/%0d/%h want 1/1/%h", k, reg_write, rd_addr, rd_data, 32'h100 + k); end
      checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL blocked_busy%0d got %h want 00000080", k, busy); end
    end
    idle();
    step();
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h12) begin errors++; $display("FAIL mdu_write got %b/%0d/%h want 1/7/12", reg_write, rd_addr, rd_data); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL mdu_busy_clear got %h want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mdu_stall got %b want 0", stall); end
    step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mdu_drained got %b want 0", reg_write); end
  endtask

  task automatic test_back_to_back();
    idle();
    pipe(5'd1, 32'hA);
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h33;
    step();
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL fill1_ready got %b want 1", mdu_ready); end
    mdu_rd = 5'd4; mdu_data = 32'h44;
    step();
    checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", mdu_ready); end
    // Offered while full: must not be taken even though a pop happens now.
    pipe_regwrite = 1'b0; pipe_rd = 5'd0;
    mdu_rd = 5'd10; mdu_data = 32'hAA;
    step();
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h33) begin errors++; $display("FAIL b2b_first got %b/%0d/%h want 1/3/33", reg_write, rd_addr, rd_data); end
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL after_pop_ready got %b want 1", mdu_ready); end
    idle();
    step();
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd4 || rd_data !== 32'h44) begin errors++; $display("FAIL b2b_second got %b/%0d/%h want 1/4/44", reg_write, rd_addr, rd_data); end
    step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL full_drop got %b want 0 (rd10 must not be accepted)", reg_write); end
  endtask

  task automatic test_rd0_drop();
    idle();
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h5555;
    step();
    idle();
    step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rd0_drop got %b want 0", reg_write); end
  endtask

  task automatic test_starve();
    idle();
    pipe(5'd2, 32'h200);
    issue_valid = 1'b1; issue_rd = 5'd6;
    mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h66;
    step();
    issue_valid = 1'b0; mdu_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pipe(5'd2, 32'h200 + k);
      step();
      checks++; if (stall !== (k == 4)) begin errors++; $display("FAIL starve_edge%0d got %b want %b", k, stall, (k == 4)); end
    end
    pipe(5'd2, 32'h2FF);
    step();
    checks++; if (stall !== 1'b1 || rd_addr !== 5'd2 || rd_data !== 32'h2FF) begin errors++; $display("FAIL stall_pipe_priority got %b/%0d/%h want 1/2/2ff", stall, rd_addr, rd_data); end
    idle();
    step();
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd6 || rd_data !== 32'h66) begin errors++; $display("FAIL starve_pop got %b/%0d/%h want 1/6/66", reg_write, rd_addr, rd_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL starve_release got %b want 0", stall); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL starve_busy got %h want 0", busy); end
  endtask

  task automatic test_reset_mid();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd2;
    step();
    issue_rd = 5'd5;
    step();
    issue_valid = 1'b0;
    pipe(5'd8, 32'h800);
    mdu_valid = 1'b1; mdu_rd = 5'd2; mdu_data = 32'h22;
    step();
    mdu_rd = 5'd5; mdu_data = 32'h55;
    step();
    checks++; if (mdu_ready !== 1'b0 || busy !== 32'h0000_0024) begin errors++; $display("FAIL premid_state got %b/%h want 0/00000024", mdu_ready, busy); end
    idle();
    rst = 1'b1;
    step();
    checks++; if (reg_write !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin errors++; $display("FAIL mid_reset_port got %b/%0d/%h want 0/0/0", reg_write, rd_addr, rd_data); end
    checks++; if (busy !== 32'd0 || stall !== 1'b0 || mdu_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_state got %h/%b/%b want 0/0/1", busy, stall, mdu_ready); end
    rst = 1'b0;
    step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mid_reset_fifo got %b want 0", reg_write); end
  endtask

  task automatic test_same_cycle();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    idle();
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
    step();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'h99) begin errors++; $display("FAIL same_pop got %b/%0d/%h want 1/9/99", reg_write, rd_addr, rd_data); end
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL same_set_wins got %h want 00000200", busy); end
    idle();
    step();
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL same_busy_hold got %h want 00000200", busy); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_pipe();
    test_mdu_delayed();
    test_back_to_back();
    test_rd0_drop();
    test_starve();
    test_reset_mid();
    test_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
